// File: rtl/md_pkg.sv
// Shared definitions for the sequential RV32M multiply/divide unit:
// funct3 encodings, FSM states and small opcode-decode helpers.
package md_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // MUL only needs the low word, which is sign-agnostic, so it is treated as unsigned.
    function automatic logic f3_signed_a(input funct3_e f);
        case (f)
            F3_MULH, F3_MULHSU, F3_DIV, F3_REM: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic f3_signed_b(input funct3_e f);
        case (f)
            F3_MULH, F3_DIV, F3_REM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic f3_is_div(input funct3_e f);
        case (f)
            F3_DIV, F3_DIVU, F3_REM, F3_REMU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    // Result comes from the upper accumulator half (high product word or remainder).
    function automatic logic f3_upper(input funct3_e f);
        case (f)
            F3_MULH, F3_MULHSU, F3_MULHU, F3_REM, F3_REMU: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shift {remainder, dividend} left by one,
// subtract the divisor when it fits and shift the quotient bit in.
module md_div_step
    import md_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2*WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0]   i_divisor,
    output logic [2*WIDTH:0]   o_acc
);

    logic [WIDTH+1:0] w_rem_sh;
    logic [WIDTH+1:0] w_diff;
    logic [WIDTH-1:0] w_quo_sh;

    assign w_rem_sh = {i_acc[2*WIDTH:WIDTH], i_acc[WIDTH-1]};
    assign w_quo_sh = {i_acc[WIDTH-2:0], 1'b0};
    assign w_diff   = w_rem_sh - {2'b00, i_divisor};

    // A clear sign bit on the difference means the divisor fits: keep it and set the quotient bit.
    always_comb begin
        o_acc = {w_rem_sh[WIDTH:0], w_quo_sh};
        if (!w_diff[WIDTH+1]) begin
            o_acc = {w_diff[WIDTH:0], w_quo_sh[WIDTH-1:1], 1'b1};
        end else begin
            o_acc = {w_rem_sh[WIDTH:0], w_quo_sh};
        end
    end

endmodule

// File: rtl/seq_mul_div.sv
// Iterative RV32M multiply/divide unit with a fixed WIDTH+3 cycle latency,
// sharing one 2*WIDTH+1-bit accumulator between shift-add and restoring divide.
module seq_mul_div
    import md_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    input  logic [4:0]       rd_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out,
    output logic             we_out
);

    localparam int                AW        = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  SEL_STEP  = CNT_W'(WIDTH + 1);

    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [AW-1:0]      r_acc;
    logic [WIDTH-1:0]   r_b;
    funct3_e            r_op;
    logic               r_sa;
    logic               r_sb;
    logic               r_div0;
    logic               r_busy;
    logic               r_done;
    logic               r_we;
    logic [WIDTH-1:0]   r_result;
    logic [4:0]         r_rd;

    funct3_e            w_op;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_mul_sum;
    logic [AW-1:0]      w_mul_acc;
    logic [AW-1:0]      w_div_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [AW-1:0]      w_fix_acc;
    logic [WIDTH-1:0]   w_sel;

    assign w_op    = funct3_e'(funct3);
    assign w_sa    = f3_signed_a(w_op) & rs1_val[WIDTH-1];
    assign w_sb    = f3_signed_b(w_op) & rs2_val[WIDTH-1];
    assign w_a_abs = w_sa ? (-rs1_val) : rs1_val;
    assign w_b_abs = w_sb ? (-rs2_val) : rs2_val;

    // Multiply step: conditionally add the multiplicand to the high half, then shift right.
    assign w_mul_sum = r_acc[AW-1:WIDTH] + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_mul_acc = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};

    md_div_step #(
        .WIDTH     (WIDTH)
    ) u_div_step (
        .i_acc     (r_acc),
        .i_divisor (r_b),
        .o_acc     (w_div_acc)
    );

    // Divide-by-zero leaves the all-ones quotient unsigned; the remainder always follows the dividend.
    assign w_prod     = r_acc[2*WIDTH-1:0];
    assign w_prod_fix = (r_sa ^ r_sb) ? (-w_prod) : w_prod;
    assign w_quo      = r_acc[WIDTH-1:0];
    assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
    assign w_quo_fix  = ((r_sa ^ r_sb) && !r_div0) ? (-w_quo) : w_quo;
    assign w_rem_fix  = r_sa ? (-w_rem) : w_rem;
    assign w_fix_acc  = f3_is_div(r_op) ? {1'b0, w_rem_fix, w_quo_fix} : {1'b0, w_prod_fix};
    assign w_sel      = f3_upper(r_op) ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; FIX spends one cycle on sign correction and one on word selection.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_CALC;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (r_cnt == LAST_STEP) begin
                    w_state_next = ST_FIX;
                end else begin
                    w_state_next = ST_CALC;
                end
            end
            ST_FIX: begin
                if (r_cnt == SEL_STEP) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_FIX;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
            r_result <= {WIDTH{1'b0}};
            r_rd     <= 5'd0;
            r_cnt    <= CNT_ZERO;
            r_acc    <= {AW{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_op     <= F3_MUL;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
            r_done <= (w_state_next == ST_DONE);
            r_we   <= (w_state_next == ST_DONE) && (r_rd != 5'd0);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op   <= w_op;
                        r_rd   <= rd_in;
                        r_sa   <= w_sa;
                        r_sb   <= w_sb;
                        r_div0 <= (rs2_val == {WIDTH{1'b0}});
                        r_b    <= w_b_abs;
                        r_cnt  <= CNT_ZERO;
                        r_acc  <= {{(WIDTH+1){1'b0}}, w_a_abs};
                    end
                end
                ST_CALC: begin
                    r_acc <= f3_is_div(r_op) ? w_div_acc : w_mul_acc;
                    r_cnt <= r_cnt + CNT_ONE;
                end
                ST_FIX: begin
                    if (r_cnt == SEL_STEP) begin
                        r_result <= w_sel;
                    end else begin
                        r_acc <= w_fix_acc;
                    end
                    r_cnt <= r_cnt + CNT_ONE;
                end
                ST_DONE: r_cnt <= r_cnt;
                default: r_cnt <= CNT_ZERO;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign we_out = r_we;
    assign result = r_result;
    assign rd_out = r_rd;

endmodule

// File: doc/seq_mul_div.md
SEQ_MUL_DIV -- requirements
Module: seq_mul_div

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock; the module SHALL use this single clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_val  input  WIDTH  operand A, driven from register-file RD1.
REQ-007 rs2_val  input  WIDTH  operand B, driven from register-file RD2.
REQ-008 rd_in  input  5  destination register address.
REQ-009 busy  output  1  high while an operation is in flight.
REQ-010 done  output  1  one-cycle pulse when result is valid.
REQ-011 result  output  WIDTH  result, driven to register-file WD3.
REQ-012 rd_out  output  5  captured rd_in, driven to register-file A3.
REQ-013 we_out  output  1  register-file write enable (WE3); equals done AND (rd_out != 0).

Function
REQ-014 FSM states SHALL be IDLE, CALC, FIX, DONE.
REQ-015 In IDLE with start=1 at edge N, the module SHALL capture funct3, rd_in, operand signs and absolute values (absolute values for signed ops only), clear the 6-bit step counter, and enter CALC.
REQ-016 CALC SHALL perform exactly WIDTH iterations, one per clock: shift-add for multiply (2*WIDTH-bit product), restoring shift-subtract for divide.
REQ-017 After the last iteration the FSM SHALL enter FIX, apply sign correction and the MULH/low-word selection, then enter DONE.
REQ-018 done SHALL be high for exactly the one cycle following edge N+WIDTH+2 (edge N+34 for WIDTH=32); the FSM SHALL then return to IDLE.
REQ-019 busy SHALL be high from edge N+1 through the DONE cycle inclusive.
REQ-020 result and rd_out SHALL hold their values after DONE until the next accepted start.
REQ-021 start while not IDLE SHALL be ignored; the in-flight operation SHALL continue unaffected.
REQ-022 start in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.
REQ-023 Divide by zero: DIV/DIVU SHALL return all ones; REM/REMU SHALL return rs1_val.
REQ-024 Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF): quotient SHALL be 0x80000000 and REM SHALL be 0.
REQ-025 Special cases SHALL keep the same fixed latency as normal operations.
REQ-026 Signed remainder SHALL take the sign of the dividend, and signed quotient SHALL truncate toward zero.
REQ-027 MULHSU SHALL treat rs1 as signed and rs2 as unsigned.
REQ-028 Operand inputs SHALL be ignored after the start edge, because the register file may change them.

Reset
REQ-029 With reset=1 at a rising edge, the FSM SHALL go to IDLE and busy, done, we_out, result and rd_out SHALL all go to 0.
REQ-030 Reset SHALL take priority over start.
REQ-031 Reset mid-operation SHALL abandon the operation without producing a done pulse.

Structure
REQ-032 Package md_pkg SHALL hold the funct3 encodings, the FSM state enum and the WIDTH default.
REQ-033 One combinational sub-module, md_div_step, SHALL implement a single restoring-divide step; the multiply step SHALL be inlined.
REQ-034 A single shared 2*WIDTH+1-bit accumulator register SHALL be used for both multiply and divide.

Verification
REQ-035 MUL 7 x 6, rd_in=5 -> done at start+34, result=42, rd_out=5, we_out=1.
REQ-036 MULH/MULHU with rs1=rs2=0xFFFFFFFF -> MULH gives 0x00000000; MULHU gives 0xFFFFFFFE; MULHSU gives 0xFFFFFFFF.
REQ-037 DIV -20/3 -> 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE; DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100.
REQ-038 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, both at the normal latency.
REQ-039 start re-pulsed at start+5 with different operands -> first result unchanged and exactly one done pulse; rd_in=0 -> done=1 with we_out=0.
REQ-040 reset asserted at start+10 -> busy=0 next cycle, no done pulse, result=0; a new start afterwards completes normally.
